alu_seq: RTL and testbench

//  Registered, parametrised ALU. Generalises the team's 8-bit combinational ALU: WIDTH-bit

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_mul_iter.sv | 77 +++++++
 rtl/alu_seq.sv | 196 +++++++++++++++++++
 tb/tb_alu_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and the
// FSM state type used by the top level.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_ADC   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_SBB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_NOT   = 4'h7;
  localparam logic [3:0] OP_SHL   = 4'h8;
  localparam logic [3:0] OP_SHR   = 4'h9;
  localparam logic [3:0] OP_SAR   = 4'hA;
  localparam logic [3:0] OP_ROL   = 4'hB;
  localparam logic [3:0] OP_INC   = 4'hC;
  localparam logic [3:0] OP_DEC   = 4'hD;
  localparam logic [3:0] OP_MUL   = 4'hE;
  localparam logic [3:0] OP_PASSB = 4'hF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one partial product per clock.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   start_i        load operands and begin (ignored semantics while busy: caller gates it)
//   a_i, b_i       Width-bit unsigned operands
//   busy_o         a multiplication is in progress
//   done_o         this cycle performs the final step; product_o is the full product
//   product_o      2*Width-bit product, valid while done_o is high
module alu_mul_iter #(
  parameter int unsigned Width = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [Width-1:0]   a_i,
  input  logic [Width-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*Width-1:0] product_o
);

  localparam int unsigned CntW = $clog2(Width);

  logic               busy_q, busy_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*Width-1:0] mcand_q, mcand_d;
  logic [Width-1:0]   mplier_q, mplier_d;
  logic [2*Width-1:0] acc_q, acc_d;
  logic [2*Width-1:0] acc_step;

  // Accumulate the shifted multiplicand when the current multiplier LSB is set.
  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = busy_q && (cnt_q == CntW'(Width - 1));
  // The last step's sum is handed out directly so the caller can register it on the same edge.
  assign product_o = acc_step;
  assign busy_o    = busy_q;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{Width{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done_o) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes, a persistent carry flag and an
// iterative multiply. Single-cycle ops register their result on the accepting edge; MUL
// holds the block BUSY for WIDTH cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (ai, bi, ci, seli)
//   out_valid / out_ready result handshake (out, carry, Z, N, V)
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CIN_SRC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ai,
  input  logic [WIDTH-1:0] bi,
  input  logic             ci,
  input  logic [3:0]       seli,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             Z,
  output logic             N,
  output logic             V
);

  localparam int unsigned ShW = $clog2(WIDTH);
  localparam int unsigned Msb = WIDTH - 1;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d, z_q, z_d, n_q, n_d, v_q, v_d;
  logic             out_valid_q, out_valid_d;

  logic             accept, cin, mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [ShW-1:0]   sh;
  logic [WIDTH:0]   add_w, sub_w, inc_w, dec_w, shl_w, shr_w;
  logic signed [WIDTH:0] sar_w;
  logic [2*WIDTH-1:0] rol_w;
  logic [WIDTH-1:0] res, ld_val;
  logic             res_c, res_v, ld_c, ld_v, load;

  assign in_ready = (state_q == IDLE) && !mul_busy && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign cin      = (CIN_SRC == 1) ? carry_q : ci;
  assign sh       = bi[ShW-1:0];

  // Widened by one bit so bit WIDTH is the carry (add) or borrow (sub).
  assign add_w = {1'b0, ai} + {1'b0, bi} + {{WIDTH{1'b0}}, (seli == OP_ADC) & cin};
  assign sub_w = {1'b0, ai} - {1'b0, bi} - {{WIDTH{1'b0}}, (seli == OP_SBB) & cin};
  assign inc_w = {1'b0, ai} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_w = {1'b0, ai} - {{WIDTH{1'b0}}, 1'b1};
  // Extra bit on the shifted-out side captures the last bit lost; it stays 0 for sh==0.
  assign shl_w = {1'b0, ai} << sh;
  assign shr_w = {ai, 1'b0} >> sh;
  assign sar_w = $signed({ai, 1'b0}) >>> sh;
  assign rol_w = {ai, ai} << sh;

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    unique case (seli)
      OP_ADD, OP_ADC: begin
        res   = add_w[WIDTH-1:0];
        res_c = add_w[WIDTH];
        res_v = (ai[Msb] == bi[Msb]) && (add_w[Msb] != ai[Msb]);
      end
      OP_SUB, OP_SBB: begin
        res   = sub_w[WIDTH-1:0];
        res_c = sub_w[WIDTH];
        res_v = (ai[Msb] != bi[Msb]) && (sub_w[Msb] != ai[Msb]);
      end
      OP_AND: res = ai & bi;
      OP_OR:  res = ai | bi;
      OP_XOR: res = ai ^ bi;
      OP_NOT: res = ~ai;
      OP_SHL: begin
        res   = shl_w[WIDTH-1:0];
        res_c = shl_w[WIDTH];
      end
      OP_SHR: begin
        res   = shr_w[WIDTH:1];
        res_c = shr_w[0];
      end
      OP_SAR: begin
        res   = sar_w[WIDTH:1];
        res_c = sar_w[0];
      end
      OP_ROL: res = rol_w[2*WIDTH-1:WIDTH];
      OP_INC: begin
        res   = inc_w[WIDTH-1:0];
        res_c = inc_w[WIDTH];
        res_v = !ai[Msb] && inc_w[Msb];
      end
      OP_DEC: begin
        res   = dec_w[WIDTH-1:0];
        res_c = dec_w[WIDTH];
        res_v = ai[Msb] && !dec_w[Msb];
      end
      OP_PASSB: res = bi;
      default: ;  // OP_MUL goes through the multiplier
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    out_d       = out_q;
    carry_d     = carry_q;
    z_d         = z_q;
    n_d         = n_q;
    v_d         = v_q;
    mul_start   = 1'b0;
    load        = 1'b0;
    ld_val      = res;
    ld_c        = res_c;
    ld_v        = res_v;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (seli == OP_MUL) begin
            state_d   = BUSY;
            mul_start = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mul_done) begin
          state_d = IDLE;
          load    = 1'b1;
          ld_val  = mul_prod[WIDTH-1:0];
          ld_c    = |mul_prod[2*WIDTH-1:WIDTH];
          ld_v    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      out_d       = ld_val;
      carry_d     = ld_c;
      v_d         = ld_v;
      z_d         = (ld_val == '0);
      n_d         = ld_val[Msb];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_q       <= '0;
      carry_q     <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      carry_q     <= carry_d;
      z_q         <= z_d;
      n_q         <= n_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
    end
  end

  alu_mul_iter #(
    .Width(WIDTH)
  ) u_mul (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (mul_start),
    .a_i      (ai),
    .b_i      (bi),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  assign out       = out_q;
  assign carry     = carry_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign V         = v_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8. Two instances share all inputs: u_dut0 takes
// carry-in from the ci port, u_dut1 from its own carry flag.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, ci;
  logic [7:0] ai, bi;
  logic [3:0] seli;

  logic       in_ready0, out_valid0, carry0, z0, n0, v0;
  logic [7:0] out0;
  logic       in_ready1, out_valid1, carry1, z1, n1, v1;
  logic [7:0] out1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8), .CIN_SRC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .ai(ai), .bi(bi),
    .ci(ci), .seli(seli), .out_valid(out_valid0), .out_ready(out_ready), .out(out0),
    .carry(carry0), .Z(z0), .N(n0), .V(v0)
  );

  alu_seq #(.WIDTH(8), .CIN_SRC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .ai(ai), .bi(bi),
    .ci(ci), .seli(seli), .out_valid(out_valid1), .out_ready(out_ready), .out(out1),
    .carry(carry1), .Z(z1), .N(n1), .V(v1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one bundle at the falling edge; returns 1ns after the accepting rising edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic c);
    @(negedge clk);
    in_valid = 1'b1;
    seli     = op;
    ai       = a;
    bi       = b;
    ci       = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic vec(input string tag, input logic [3:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic c, input logic [7:0] eo,
                     input logic ec, input logic ev);
    send(op, a, b, c);
    check({tag, ".valid"}, out_valid0, 1);
    check({tag, ".out"}, out0, eo);
    check({tag, ".carry"}, carry0, ec);
    check({tag, ".V"}, v0, ev);
    check({tag, ".Z"}, z0, eo == 8'h00);
    check({tag, ".N"}, n0, eo[7]);
  endtask

  initial begin
    int bad;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ai        = '0;
    bi        = '0;
    ci        = 1'b0;
    seli      = '0;
    #12;
    check("rst.valid", out_valid0, 0);
    check("rst.out", out0, 0);
    check("rst.flags", {carry0, z0, n0, v0}, 4'b0000);
    check("rst.in_ready", in_ready0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    //      tag         op     a      b      ci    out    c     v
    vec("adc",     4'h1, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
    vec("sub",     4'h2, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0);
    vec("add_ov",  4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    vec("sbb",     4'h3, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0);
    vec("sbb0",    4'h3, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    vec("sub_ov",  4'h2, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    vec("and",     4'h4, 8'h0F, 8'h35, 1'b1, 8'h05, 1'b0, 1'b0);
    vec("or",      4'h5, 8'hF0, 8'h0C, 1'b0, 8'hFC, 1'b0, 1'b0);
    vec("not",     4'h7, 8'h0F, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0);
    vec("shl",     4'h8, 8'h81, 8'h01, 1'b0, 8'h02, 1'b1, 1'b0);
    vec("shl_msk", 4'h8, 8'h01, 8'h09, 1'b0, 8'h02, 1'b0, 1'b0);
    vec("shr",     4'h9, 8'h03, 8'h01, 1'b0, 8'h01, 1'b1, 1'b0);
    vec("shr0",    4'h9, 8'h05, 8'h00, 1'b0, 8'h05, 1'b0, 1'b0);
    vec("sar",     4'hA, 8'h80, 8'h03, 1'b0, 8'hF0, 1'b0, 1'b0);
    vec("sar_c",   4'hA, 8'h84, 8'h03, 1'b0, 8'hF0, 1'b1, 1'b0);
    vec("rol",     4'hB, 8'h81, 8'h01, 1'b0, 8'h03, 1'b0, 1'b0);
    vec("rol4",    4'hB, 8'h81, 8'h04, 1'b0, 8'h18, 1'b0, 1'b0);
    vec("inc_ov",  4'hC, 8'h7F, 8'h00, 1'b0, 8'h80, 1'b0, 1'b1);
    vec("inc_wr",  4'hC, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    vec("dec_wr",  4'hD, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0);
    vec("dec_ov",  4'hD, 8'h80, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b1);
    vec("pass",    4'hF, 8'h12, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0);

    // MUL 10*10: busy for 8 cycles, result on the 8th edge after accept.
    send(4'hE, 8'h10, 8'h10, 1'b0);
    bad = 0;
    if (in_ready0 || out_valid0) bad++;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (in_ready0 || out_valid0) bad++;
    end
    check("mul.busy_cycles", bad, 0);
    @(posedge clk);
    #1;
    check("mul.valid_at_8", out_valid0, 1);
    check("mul.out", out0, 8'h00);
    check("mul.flags", {carry0, z0, n0, v0}, 4'b1100);

    send(4'hE, 8'h0D, 8'h0B, 1'b0);
    repeat (8) begin
      @(posedge clk);
    end
    #1;
    check("mul2.valid", out_valid0, 1);
    check("mul2.out", out0, 8'h8F);
    check("mul2.carry", carry0, 0);

    // Backpressure: let the MUL result drain, then stall the consumer.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(4'h6, 8'hF0, 8'h3C, 1'b0);
    check("bp.out", out0, 8'hCC);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready0 || !out_valid0 || out0 !== 8'hCC || {carry0, z0, n0, v0} !== 4'b0010)
        bad++;
    end
    check("bp.hold", bad, 0);
    in_valid  = 1'b1;
    seli      = 4'h4;
    ai        = 8'h0F;
    bi        = 8'h35;
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", in_ready0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp.next_valid", out_valid0, 1);
    check("bp.next_out", out0, 8'h05);

    // Carry-flag chaining on the CIN_SRC=1 instance.
    send(4'h0, 8'hFF, 8'h01, 1'b0);
    check("cin1.add", {out1, carry1}, {8'h00, 1'b1});
    send(4'h1, 8'h00, 8'h00, 1'b0);
    check("cin1.adc", {out1, carry1}, {8'h01, 1'b0});
    check("cin0.adc", {out0, carry0}, {8'h00, 1'b0});

    // Reset in the middle of a multiply.
    send(4'hF, 8'h00, 8'hFF, 1'b0);
    send(4'hE, 8'h03, 8'h03, 1'b0);
    repeat (4) begin
      @(posedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst.valid", out_valid0, 0);
    check("mrst.out", out0, 8'h00);
    check("mrst.flags", {carry0, z0, n0, v0}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrst.in_ready", in_ready0, 1);
    send(4'h0, 8'h01, 8'h02, 1'b0);
    check("mrst.add", {out_valid0, out0}, {1'b1, 8'h03});
    repeat (10) begin
      @(posedge clk);
    end
    #1;
    check("mrst.no_stale", out0, 8'h03);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
